// File: rtl/laserdrop_pkg.sv
// Shared LaserDrop types and constants for the FTDI 245-style FIFO link.
package laserdrop_pkg;

  localparam int unsigned FTDI_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_LOW  = 2'd1,
    RD_HIGH = 2'd2
  } ftdi_rd_state_t;

endpackage

// File: rtl/ftdi_fifo_reader_byte_fifo.sv
// First-word-fall-through byte buffer; the head entry is always visible on rd_data.
module byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  // Pointers are PTR_W bits wide, so wrap modulo DEPTH falls out naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_ok    = wr_en && !full;
    rd_ok    = rd_en && !empty;
    if (wr_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ftdi_fifo_reader.sv
// Host-to-FPGA FTDI 245 reader: paces RD# around RXF# and streams captured bytes out.
module ftdi_fifo_reader
  import laserdrop_pkg::*;
#(
  parameter int unsigned RD_LOW_CYCLES  = 3,
  parameter int unsigned RD_HIGH_CYCLES = 5,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   rxf,
  input  logic [FTDI_BYTE_W-1:0] adbus_in,
  input  logic                   bus_grant,
  output logic                   bus_req,
  output logic                   ftdi_rd,
  output logic [FTDI_BYTE_W-1:0] data_out,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic [15:0]            byte_count
);

  ftdi_rd_state_t state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [15:0]    byte_count_q, byte_count_d;
  logic           rxf_meta_q, rxf_s_q;
  logic           fifo_wr;
  logic           fifo_full;
  logic           fifo_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxf_meta_q <= 1'b1;
      rxf_s_q    <= 1'b1;
    end else begin
      rxf_meta_q <= rxf;
      rxf_s_q    <= rxf_meta_q;
    end
  end

  // RD# and bus_req decode straight from state so reset raises RD# without a clock.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    byte_count_d = byte_count_q;
    fifo_wr      = 1'b0;
    bus_req      = 1'b0;
    ftdi_rd      = 1'b1;
    case (state_q)
      IDLE: begin
        bus_req = en && !rxf_s_q && !fifo_full;
        if (bus_req && bus_grant) begin
          state_d = RD_LOW;
          cnt_d   = '0;
        end
      end
      RD_LOW: begin
        ftdi_rd = 1'b0;
        bus_req = 1'b1;
        if (cnt_q == 4'(RD_LOW_CYCLES - 1)) begin
          fifo_wr      = 1'b1;
          byte_count_d = byte_count_q + 16'd1;
          state_d      = RD_HIGH;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RD_HIGH: begin
        if (cnt_q == 4'(RD_HIGH_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign byte_count = byte_count_q;
  assign data_valid = !fifo_empty;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FTDI_BYTE_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (adbus_in),
    .rd_en   (data_ready),
    .rd_data (data_out),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_ftdi_fifo_reader.sv
// Scoreboard bench for ftdi_fifo_reader with a simple FTDI host model driving RXF#/ADBUS.
module tb_ftdi_fifo_reader;

  localparam int unsigned RD_LOW  = 3;
  localparam int unsigned RD_HIGH = 5;
  localparam int unsigned DEPTH   = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic        bus_grant;
  logic        data_ready;
  logic        rxf;
  logic [7:0]  adbus_in;
  logic        bus_req;
  logic        ftdi_rd;
  logic [7:0]  data_out;
  logic        data_valid;
  logic [15:0] byte_count;

  logic        model_on = 1'b0;
  logic        rxf_man  = 1'b1;
  logic [7:0]  adbus_man = 8'h00;
  logic [7:0]  model_byte = 8'hEE;
  int          pend_n = 0;

  logic [7:0]  pend[$];
  logic [7:0]  exp_q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_falls = 0;
  int          n_caps = 0;
  int          n_rx = 0;
  int          low_len = 0;
  int          prev_fall = 0;
  logic        prev_rd = 1'b1;
  logic        have_prev = 1'b0;
  logic        chk_period = 1'b0;
  logic [15:0] exp_base = 16'h0000;
  int          caps0 = 0;

  assign rxf      = model_on ? (pend_n == 0) : rxf_man;
  assign adbus_in = model_on ? model_byte : adbus_man;

  always #5 clock = ~clock;

  ftdi_fifo_reader #(
    .RD_LOW_CYCLES  (RD_LOW),
    .RD_HIGH_CYCLES (RD_HIGH),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .rxf        (rxf),
    .adbus_in   (adbus_in),
    .bus_grant  (bus_grant),
    .bus_req    (bus_req),
    .ftdi_rd    (ftdi_rd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .byte_count (byte_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Host model + RD# timing monitor + output scoreboard, all sampled on negedge.
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      low_len = 0;
    end else begin
      if (!ftdi_rd) low_len++;
      if (prev_rd && !ftdi_rd) begin
        n_falls++;
        if (chk_period && have_prev) check_eq("rd_period", cyc - prev_fall, RD_LOW + RD_HIGH + 1);
        prev_fall = cyc;
        have_prev = 1'b1;
      end
      if (!prev_rd && ftdi_rd) begin
        check_eq("rd_low_len", low_len, RD_LOW);
        low_len = 0;
        n_caps++;
        check_eq("byte_count", byte_count, 16'(exp_base + 16'(n_caps - caps0)));
        if (model_on && pend.size() > 0) exp_q.push_back(pend.pop_front());
      end
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_pending", exp_q.size(), 1);
        end else begin
          check_eq("sb_data", data_out, exp_q.pop_front());
          n_rx++;
        end
      end
    end
    if (!chk_period) have_prev = 1'b0;
    prev_rd    = ftdi_rd;
    pend_n     = pend.size();
    model_byte = (pend.size() > 0) ? pend[0] : 8'hEE;
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_rd(input logic level, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clock);
      if (ftdi_rd === level) break;
    end
    check_eq("wait_rd", ftdi_rd, level);
  endtask

  task automatic wait_drain(input int max);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clock);
      done = (pend.size() == 0) && (exp_q.size() == 0);
    end
    check_eq("drain", done, 1);
    repeat (12) @(negedge clock);
  endtask

  int f0;
  int r0;
  logic done;

  initial begin
    reset = 1'b1; en = 1'b0; bus_grant = 1'b0; data_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_rd", ftdi_rd, 1);
    check_eq("rst_req", bus_req, 0);
    check_eq("rst_valid", data_valid, 0);
    check_eq("rst_dout", data_out, 0);
    check_eq("rst_count", byte_count, 0);
    step();
    reset = 1'b0;
    repeat (2) step();

    // Single byte with exact RD# latency.
    en = 1'b1; bus_grant = 1'b1; adbus_man = 8'hA5; rxf_man = 1'b0;
    exp_q.push_back(8'hA5);
    @(negedge clock); check_eq("lat_e0", ftdi_rd, 1);
    @(negedge clock); check_eq("lat_e1", ftdi_rd, 1);
    @(negedge clock); check_eq("lat_e2", ftdi_rd, 1); check_eq("lat_req", bus_req, 1);
    @(negedge clock); check_eq("lat_e3", ftdi_rd, 0);
    @(negedge clock); check_eq("low_e4", ftdi_rd, 0);
    @(negedge clock); check_eq("low_e5", ftdi_rd, 0); check_eq("pre_valid", data_valid, 0);
    @(negedge clock);
    check_eq("single_rd", ftdi_rd, 1);
    check_eq("single_valid", data_valid, 1);
    check_eq("single_data", data_out, 8'hA5);
    check_eq("single_count", byte_count, 1);
    step();
    rxf_man = 1'b0 | 1'b1; data_ready = 1'b1;
    wait_drain(40);

    // Burst of ten with period checking.
    step();
    f0 = n_falls; r0 = n_rx;
    for (int i = 0; i < 10; i++) pend.push_back(8'(i));
    chk_period = 1'b1; model_on = 1'b1;
    wait_drain(200);
    chk_period = 1'b0;
    check_eq("burst_reads", n_falls - f0, 10);
    check_eq("burst_rx", n_rx - r0, 10);
    check_eq("burst_count", byte_count, 11);

    // Backpressure: buffer fills after four reads.
    step();
    data_ready = 1'b0;
    f0 = n_falls; r0 = n_rx;
    for (int i = 0; i < 8; i++) pend.push_back(8'(8'h40 + i));
    repeat (80) @(negedge clock);
    check_eq("bp_reads", n_falls - f0, 4);
    check_eq("bp_req", bus_req, 0);
    check_eq("bp_rd", ftdi_rd, 1);
    check_eq("bp_valid", data_valid, 1);
    check_eq("bp_head", data_out, 8'h40);
    step();
    data_ready = 1'b1;
    wait_drain(300);
    check_eq("bp_reads_all", n_falls - f0, 8);
    check_eq("bp_rx", n_rx - r0, 8);

    // Grant withheld, then enable dropped.
    step();
    model_on = 1'b0; rxf_man = 1'b0; bus_grant = 1'b0; en = 1'b1;
    f0 = n_falls;
    repeat (5) @(negedge clock);
    check_eq("ng_req", bus_req, 1);
    check_eq("ng_rd", ftdi_rd, 1);
    step();
    en = 1'b0;
    @(negedge clock);
    check_eq("noen_req", bus_req, 0);
    check_eq("ng_reads", n_falls - f0, 0);

    // Enable and grant drop mid RD_LOW: byte completes, no further read.
    step();
    en = 1'b1; bus_grant = 1'b1; adbus_man = 8'h3C;
    exp_q.push_back(8'h3C);
    wait_rd(0, 10);
    step();
    en = 1'b0; bus_grant = 1'b0;
    repeat (20) @(negedge clock);
    check_eq("endrop_reads", n_falls - f0, 1);
    check_eq("endrop_req", bus_req, 0);
    check_eq("endrop_rd", ftdi_rd, 1);
    check_eq("endrop_sb", exp_q.size(), 0);
    step();
    rxf_man = 1'b1; en = 1'b1; bus_grant = 1'b1;
    repeat (4) @(negedge clock);

    // Reset during RD_LOW with a byte already buffered.
    step();
    data_ready = 1'b0; adbus_man = 8'h11; rxf_man = 1'b0;
    wait_rd(0, 10);
    wait_rd(1, 10);
    adbus_man = 8'h77;
    wait_rd(0, 20);
    step();
    reset = 1'b1;
    #1;
    check_eq("mr_rd", ftdi_rd, 1);
    check_eq("mr_valid", data_valid, 0);
    check_eq("mr_count", byte_count, 0);
    check_eq("mr_req", bus_req, 0);
    rxf_man = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    exp_base = 16'h0000; caps0 = n_caps; f0 = n_falls;
    repeat (15) @(negedge clock);
    check_eq("post_rd", ftdi_rd, 1);
    check_eq("post_valid", data_valid, 0);
    check_eq("post_count", byte_count, 0);
    check_eq("post_reads", n_falls - f0, 0);

    // Counter wrap plus random backpressure to wrap the buffer pointers.
    step();
    force dut.byte_count_q = 16'hFFFE;
    step();
    release dut.byte_count_q;
    exp_base = 16'hFFFE; caps0 = n_caps;
    @(negedge clock);
    check_eq("wrap_base", byte_count, 16'hFFFE);
    step();
    r0 = n_rx;
    for (int i = 0; i < 20; i++) pend.push_back(8'($urandom_range(0, 255)));
    model_on = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 800 && !done; i++) begin
      step();
      data_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      done = (pend.size() == 0) && (exp_q.size() == 0);
    end
    check_eq("wrap_done", done, 1);
    step();
    data_ready = 1'b1;
    repeat (12) @(negedge clock);
    check_eq("wrap_rx", n_rx - r0, 20);
    check_eq("wrap_count", byte_count, 16'h0012);
    check_eq("sb_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
